// File: rtl/fifo_read_arbiter.sv
// Round-robin burst scheduler for the async FIFO read port, feeding tagged words to NREQ consumers.
// Define FIFO_ARB_STATS_EN to build the saturating pop_count statistics counter.
module fifo_read_arbiter #(
   parameter int unsigned DSIZE = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = 2,
   parameter int unsigned BURST = 4
) (
   input  logic             rclk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [DSIZE-1:0] fifo_rdata,
   output logic             fifo_rd,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  ready,
   output logic [NREQ-1:0]  gnt,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic [IDW-1:0]   out_id,
   output logic [15:0]      pop_count
);

   localparam int unsigned CW = $clog2(BURST) + 1;

   typedef enum logic [1:0] {StIdle, StBurst, StFlush} state_e;

   state_e           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [DSIZE-1:0] data_q, data_d;
   logic [IDW-1:0]   arb_idx, scan;
   logic             arb_found;
   logic             pop;

   // Scan starts one past the last granted consumer and wraps at NREQ-1.
   always_comb begin
      arb_idx   = '0;
      arb_found = 1'b0;
      scan      = last_q;
      for (int k = 0; k < NREQ; k++) begin
         scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + IDW'(1);
         if (!arb_found && req[scan]) begin
            arb_found = 1'b1;
            arb_idx   = scan;
         end
      end
   end

   assign pop = (state_q == StBurst) & ~fifo_empty & req[id_q] & (~valid_q | ready[id_q]);

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      id_d    = id_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (arb_found && !fifo_empty) begin
               gnt_d   = NREQ'(1) << arb_idx;
               id_d    = arb_idx;
               cnt_d   = '0;
               state_d = StBurst;
            end
         end
         StBurst: begin
            if (pop) begin
               data_d  = fifo_rdata;
               valid_d = 1'b1;
               cnt_d   = cnt_q + CW'(1);
            end else if (valid_q && ready[id_q]) begin
               valid_d = 1'b0;
            end
            if ((pop && cnt_q == CW'(BURST - 1)) || !req[id_q] || (fifo_empty && !pop)) begin
               last_d  = id_q;
               state_d = StFlush;
            end
         end
         StFlush: begin
            // Grant is released on the same edge the last word leaves the output stage.
            if (!valid_q || ready[id_q]) begin
               valid_d = 1'b0;
               gnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         id_q    <= '0;
         last_q  <= IDW'(NREQ - 1);
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         id_q    <= id_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign fifo_rd   = pop;
   assign gnt       = gnt_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_id    = id_q;

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] pop_count_q;

   always_ff @(posedge rclk or posedge rst) begin
      if (rst) begin
         pop_count_q <= '0;
      end else if (pop && pop_count_q != 16'hFFFF) begin
         pop_count_q <= pop_count_q + 16'd1;
      end
   end

   assign pop_count = pop_count_q;
`else
   assign pop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed and randomized bench for fifo_read_arbiter, checked against a cycle-level
// behavioural model of the scheduling rules and a queue model of the FIFO.
module tb_fifo_read_arbiter;

   localparam int unsigned DSIZE = 8;
   localparam int unsigned NREQ  = 4;
   localparam int unsigned IDW   = 2;
   localparam int unsigned BURST = 4;

   logic             rclk, rst, fifo_empty, fifo_rd, out_valid;
   logic [DSIZE-1:0] fifo_rdata, out_data;
   logic [NREQ-1:0]  req, ready, gnt;
   logic [IDW-1:0]   out_id;
   logic [15:0]      pop_count;

   fifo_read_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .BURST(BURST)) dut (
      .rclk(rclk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd(fifo_rd), .req(req), .ready(ready), .gnt(gnt), .out_valid(out_valid),
      .out_data(out_data), .out_id(out_id), .pop_count(pop_count)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int errors = 0;
   int checks = 0;

   // FIFO contents and reference model state
   logic [DSIZE-1:0] fq[$];
   logic [DSIZE-1:0] dq2[$];
   logic [DSIZE-1:0] exp2[$];
   int               m_ph, m_g, m_last, m_cnt, m_id, m_pc, pop_total;
   bit               m_ov;
   logic [DSIZE-1:0] m_data;

   // Observations taken at each sampling point
   bit               s_rd, s_ov;
   logic [DSIZE-1:0] s_data, hold;
   logic [NREQ-1:0]  prev_gnt, glog_mask;
   int               glog_n;
   int               dlv_cnt[NREQ];
   logic [9:0]       rd_mask;
   int               rd_n, guard;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic refresh();
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
   endtask

   task automatic push(input int n, input logic [DSIZE-1:0] base);
      for (int i = 0; i < n; i++) fq.push_back(base + DSIZE'(i));
      refresh();
   endtask

   function automatic int rr(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return 0;
   endfunction

   task automatic model_reset();
      m_ph = 0; m_g = 0; m_last = NREQ - 1; m_cnt = 0; m_id = 0; m_pc = 0;
      m_ov = 1'b0; m_data = '0; prev_gnt = '0;
   endtask

   // One clock: check outputs at the falling edge, advance the model, then update the FIFO.
   task automatic tick();
      logic [NREQ-1:0] e;
      bit p, ex;
      @(negedge rclk);
      e = '0;
      if (m_ph != 0) e[m_g] = 1'b1;
      p = (m_ph == 1) && !fifo_empty && req[m_g] && (!m_ov || ready[m_g]);
      chk("gnt", 32'(gnt), 32'(e));
      chk("fifo_rd", 32'(fifo_rd), 32'(p));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_id", 32'(out_id), 32'(m_id));
      chk("pop_count", 32'(pop_count), 32'(m_pc));
      s_rd = fifo_rd; s_ov = out_valid; s_data = out_data;
      if (out_valid && ready[out_id]) begin
         dlv_cnt[out_id]++;
         if (out_id == 2) dq2.push_back(out_data);
      end
      if (gnt != '0 && prev_gnt == '0) begin
         glog_mask |= gnt;
         glog_n++;
      end
      prev_gnt = gnt;
      case (m_ph)
         0: if (req != '0 && !fifo_empty) begin
               m_g = rr(req, m_last); m_id = m_g; m_cnt = 0; m_ph = 1;
            end
         1: begin
               ex = (p && m_cnt == BURST - 1) || !req[m_g] || (fifo_empty && !p);
               if (p) begin
                  m_data = fifo_rdata; m_ov = 1'b1; m_cnt++;
               end else if (m_ov && ready[m_g]) begin
                  m_ov = 1'b0;
               end
               if (ex) begin
                  m_last = m_g; m_ph = 2;
               end
            end
         default: if (!m_ov || ready[m_g]) begin
               m_ov = 1'b0; m_ph = 0;
            end
      endcase
`ifdef FIFO_ARB_STATS_EN
      if (p && m_pc < 16'hFFFF) m_pc++;
`endif
      @(posedge rclk);
      #1;
      if (p) begin
         void'(fq.pop_front());
         pop_total++;
      end
      refresh();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst = 1'b0; req = '0; ready = '1; pop_total = 0;
      glog_mask = '0; glog_n = 0;
      for (int i = 0; i < NREQ; i++) dlv_cnt[i] = 0;
      model_reset();
      refresh();
      #3 rst = 1'b1;
      #2;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_fifo_rd", 32'(fifo_rd), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_pop_count", 32'(pop_count), 0);
      @(posedge rclk);
      @(posedge rclk);
      #1 rst = 1'b0;

      // Single requester: 4-word burst, 2-cycle gap, then the remaining 2 words.
      push(6, 8'hA0);
      req = 4'b0001;
      rd_mask = '0;
      for (int i = 0; i < 10; i++) begin
         tick();
         rd_mask[i] = s_rd;
      end
      chk("single_rd_pattern", 32'(rd_mask), 32'h19E);
      ticks(2);
      chk("single_delivered", 32'(dlv_cnt[0]), 6);
      req = '0;
      ticks(3);

      // All requesting with 16 words: each consumer granted once for 4 words.
      for (int i = 0; i < NREQ; i++) dlv_cnt[i] = 0;
      glog_mask = '0; glog_n = 0;
      push(16, 8'h10);
      req = 4'b1111;
      ticks(30);
      chk("rr_grant_count", 32'(glog_n), 4);
      chk("rr_grant_distinct", 32'(glog_mask), 32'hF);
      for (int i = 0; i < NREQ; i++) chk("rr_words_per_consumer", 32'(dlv_cnt[i]), 4);
      req = '0;
      ticks(3);

      // Consumer 2 stalls via ready[2] for 5 cycles after its first word.
      dq2.delete();
      exp2.delete();
      for (int i = 0; i < 6; i++) exp2.push_back(8'h50 + DSIZE'(i));
      push(6, 8'h50);
      req = 4'b0100;
      guard = 0;
      do begin
         tick();
         guard++;
      end while (!s_ov && guard < 6);
      chk("stall_first_word_seen", 32'(s_ov), 1);
      ready = 4'b1011;
      hold = out_data;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_no_pop", 32'(s_rd), 0);
         chk("stall_data_held", 32'(s_data), 32'(hold));
      end
      ready = 4'b1111;
      ticks(16);
      chk("stall_delivered", 32'(dq2.size()), 6);
      for (int i = 0; i < 6 && i < dq2.size(); i++) chk("stall_order", 32'(dq2[i]), 32'(exp2[i]));
      req = '0;
      ticks(3);

      // Two words, two requesters: consumer 0 exits on empty, consumer 1 waits for data.
      push(2, 8'hC0);
      req = 4'b0011;
      rd_n = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         rd_n += int'(s_rd);
      end
      chk("empty_pops", 32'(rd_n), 2);
      chk("empty_no_grant", 32'(gnt), 0);
      push(3, 8'hD0);
      ticks(2);
      chk("empty_next_grant", 32'(gnt), 32'b0010);
      ticks(10);
      req = '0;
      ticks(3);

      // Asynchronous reset in the middle of a burst.
      push(8, 8'hE0);
      req = 4'b1111;
      ticks(3);
      chk("pre_rst_out_valid", 32'(out_valid), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_gnt", 32'(gnt), 0);
      chk("mid_rst_fifo_rd", 32'(fifo_rd), 0);
      chk("mid_rst_out_valid", 32'(out_valid), 0);
      chk("mid_rst_out_data", 32'(out_data), 0);
      chk("mid_rst_out_id", 32'(out_id), 0);
      chk("mid_rst_pop_count", 32'(pop_count), 0);
      @(posedge rclk);
      @(posedge rclk);
      #1 rst = 1'b0;
      model_reset();
      ticks(2);
      chk("post_rst_grant0", 32'(gnt), 32'b0001);
      req = '0;
      ticks(14);

      // Randomized requests, readiness and FIFO refills.
      for (int i = 0; i < 300; i++) begin
         req = NREQ'($urandom);
         ready = NREQ'($urandom);
         if (fq.size() < 12 && $urandom_range(0, 3) != 0) fq.push_back(DSIZE'($urandom));
         refresh();
         tick();
      end
      req = '0;
      ready = '1;
      ticks(12);

`ifdef FIFO_ARB_STATS_EN
      req = 4'b0001;
      guard = 0;
      while (pop_total < 65540 && guard < 98500) begin
         if (fq.size() < 6) push(6, DSIZE'($urandom));
         tick();
         guard++;
      end
      chk("stats_saturated", 32'(pop_count), 32'hFFFF);
`else
      chk("stats_disabled", 32'(pop_count), 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_read_arbiter.md
Name: fifo_read_arbiter

Overview:
Round-robin scheduler that shares the single read port of the async FIFO between NREQ consumers in the read clock domain. It watches the FIFO empty flag and drives the FIFO read strobe. It grants one consumer at a time for a burst of up to BURST words and delivers each word through a one-deep registered output stage, tagged with the consumer index. The block sits between the FIFO read-side pointer/flag logic plus memory and the downstream consumers.

Parameters:
DSIZE, 8, FIFO data width.
NREQ, 4, number of consumers (2..8).
IDW, 2, width of consumer index; must satisfy 2**IDW >= NREQ.
BURST, 4, maximum words popped per grant (1..16).

Ports:
rclk  input  1  read-domain clock.
rst  input  1  reset, asynchronous, active-high.
fifo_empty  input  1  FIFO empty flag, registered in rclk domain.
fifo_rdata  input  DSIZE  FIFO word at the current read address; first-word-fall-through, valid whenever fifo_empty=0.
fifo_rd  output  1  read strobe to FIFO; asserted only when fifo_empty=0.
req  input  NREQ  per-consumer request, level.
ready  input  NREQ  per-consumer accept for the output stage.
gnt  output  NREQ  one-hot current grant; all zero when no grant.
out_valid  output  1  output stage holds a word.
out_data  output  DSIZE  word in the output stage.
out_id  output  IDW  consumer index the word belongs to.
pop_count  output  16  total words popped (feature-dependent, see below).

Behaviour:
- Reset (asynchronous): state IDLE; gnt=0, fifo_rd=0, out_valid=0, out_data=0, out_id=0, pop_count=0; round-robin pointer last=NREQ-1, so consumer 0 has first priority.
- States: IDLE, BURST, FLUSH.
- IDLE: if req!=0 and fifo_empty=0, pick the first requester after last (wrapping modulo NREQ). Register gnt and out_id and load burst counter cnt=0. Go to BURST on the next edge. The decision takes one cycle; nothing is popped in IDLE.
- BURST: pop = ~fifo_empty & req[g] & (~out_valid | ready[g]), where g is the granted index.
  - fifo_rd = pop, combinational from registered state and inputs.
  - On a pop edge: out_data<=fifo_rdata, out_valid<=1, cnt<=cnt+1.
  - If out_valid and ready[g] and no pop: out_valid<=0.
  - Output handshake: a word transfers on the edge where out_valid & ready[g].
- BURST exit: leave on the edge where any of the following holds: (pop and cnt==BURST-1), or req[g]=0, or (fifo_empty=1 and no pop). Set last<=g and go to FLUSH.
- FLUSH: gnt stays asserted and fifo_rd=0 until out_valid clears through ready[g]. Then gnt<=0 and go to IDLE.
  - If out_valid=0 on entry, FLUSH lasts exactly one cycle.
- Throughput: one word per cycle in BURST while ready[g]=1 and the FIFO is non-empty. Maximum burst latency from grant to first out_valid is 1 cycle.
- Arithmetic: cnt is clog2(BURST)+1 bits and never exceeds BURST-1 before the exit compare. The round-robin search wraps modulo NREQ. Indices >= NREQ are never granted.
- Boundary cases:
  - FIFO goes empty mid-burst: the burst ends early and the next grant goes to the following requester.
  - req[g] drops mid-burst: no further pops; the pending word still drains in FLUSH even if req[g]=0.
  - ready[g] low for a long time: pops stall and the grant is held, with no timeout.
  - Single requester: re-granted after each burst with IDLE→BURST overhead of 2 cycles.
  - req changes in IDLE: sampled on the arbitration edge only.
- fifo_rd is never asserted while fifo_empty=1, in any state.
- Reset mid-burst: all state clears immediately. Any word in the output stage is lost; the FIFO pointer retains only pops already strobed.

Optional Feature:
FIFO_ARB_STATS_EN
- Defined: pop_count increments on every fifo_rd edge, saturates at 16'hFFFF, and clears only on rst.
- Undefined: pop_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset, then fifo_empty=0, req=4'b0001, ready=1, 6 words A0..A5 available → gnt=0001. Words A0..A3 out with out_id=0, one per cycle, fifo_rd high 4 cycles. Gnt drops, and after 2 idle cycles A4, A5 follow in a new burst.
- req=4'b1111, ready=all 1, FIFO holds 16 words → grants in order 0,1,2,3, 4 words each. No consumer is granted twice before all have had a grant.
- Consumer 2 granted, ready[2] low for 5 cycles after the first word → fifo_rd=0 those cycles, out_valid held with out_data unchanged. Resumes on ready[2]=1 with no word lost or duplicated.
- FIFO holds 2 words, req=4'b0011 → consumer 0 pops 2 and exits on empty. Consumer 1 is granted only after fifo_empty deasserts, and fifo_rd never pulses while empty.
- rst asserted in BURST with out_valid=1 → all outputs 0 immediately, asynchronously. The next arbitration after release starts from consumer 0.
- With FIFO_ARB_STATS_EN defined, 70000 pops → pop_count=16'hFFFF. Without the macro, pop_count=0 throughout.
